// File: rtl/lane_mask_combiner.sv
// Lane-masking stage: per-source compare FIFOs feed a configurable LF/HF combine
// that zeroes real or complex lanes of each data beat, with frame-locked config.
module lane_mask_combiner #(
  parameter int NUM_LANES  = 8,
  parameter int LANE_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_switch,
  input  logic [1:0]                      i_config_mode,
  input  logic [NUM_LANES-1:0]            i_lf_cmp,
  input  logic                            i_lf_valid,
  input  logic [NUM_LANES-1:0]            i_hf_cmp,
  input  logic                            i_hf_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] i_x0,
  input  logic                            i_x0_valid,
  input  logic                            i_sof,
  input  logic                            i_clr_err,
  output logic [NUM_LANES*LANE_WIDTH-1:0] o_y0,
  output logic                            o_y0_valid,
  output logic                            o_y0_sof,
  output logic [NUM_LANES-1:0]            o_lane_keep,
  output logic [CNT_WIDTH-1:0]            o_keep_cnt,
  output logic                            o_ovf,
  output logic                            o_unf
);

  localparam int HALF = NUM_LANES / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BCW  = $clog2(NUM_LANES + 1);
  localparam int SW   = ((CNT_WIDTH > BCW) ? CNT_WIDTH : BCW) + 1;
  localparam int DW   = NUM_LANES * LANE_WIDTH;

  function automatic logic [BCW-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [BCW-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_LANES; k++) n = n + BCW'(v[k]);
    return n;
  endfunction

  logic                 real_q, cfg_seen_q;
  logic [1:0]           comb_q;
  logic                 sof_beat, eff_real;
  logic [1:0]           eff_comb;

  // Index 0 is the LF FIFO, index 1 the HF FIFO.
  logic [AW:0]          wr_ptr [2];
  logic [AW:0]          rd_ptr [2];
  logic [NUM_LANES-1:0] mem    [2][FIFO_DEPTH];
  logic [1:0]           push_req, pop_req, hold, empty, full;
  logic [1:0]           pop_ok, push_ok, ovf_evt, unf_evt;
  logic [NUM_LANES-1:0] lf_v, hf_v, c, keep, keep_cplx;
  logic [BCW-1:0]       beat_cnt;

  logic                 s1_valid, s1_sof;
  logic [DW-1:0]        s1_data;
  logic [NUM_LANES-1:0] s1_keep;
  logic [BCW-1:0]       s1_cnt;
  logic [DW-1:0]        y_next;
  logic [SW-1:0]        cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Until the first SOF has been seen, the live configuration inputs steer the datapath.
  always_comb begin
    sof_beat = i_x0_valid & i_sof;
    eff_real = (sof_beat || !cfg_seen_q) ? i_switch      : real_q;
    eff_comb = (sof_beat || !cfg_seen_q) ? i_config_mode : comb_q;
    hold     = {eff_comb == 2'b10, eff_comb == 2'b11};
    push_req = {i_hf_valid, i_lf_valid};
    pop_req  = {i_x0_valid & ~hold[1], i_x0_valid & ~hold[0]};
    for (int i = 0; i < 2; i++) begin
      empty[i]   = (wr_ptr[i] == rd_ptr[i]);
      full[i]    = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                   (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      pop_ok[i]  = pop_req[i] & ~empty[i];
      unf_evt[i] = pop_req[i] & empty[i];
      push_ok[i] = push_req[i] & ~hold[i] & (~full[i] | pop_ok[i]);
      ovf_evt[i] = push_req[i] & ~hold[i] & full[i] & ~pop_ok[i];
    end
    lf_v = pop_ok[0] ? mem[0][rd_ptr[0][AW-1:0]] : '0;
    hf_v = pop_ok[1] ? mem[1][rd_ptr[1][AW-1:0]] : '0;
    case (eff_comb)
      2'b00:   c = lf_v & hf_v;
      2'b01:   c = lf_v | hf_v;
      2'b10:   c = lf_v;
      default: c = hf_v;
    endcase
    keep_cplx = '0;
    for (int j = 0; j < HALF; j++) begin
      keep_cplx[2*j]   = c[j];
      keep_cplx[2*j+1] = c[j];
    end
    keep     = eff_real ? c : keep_cplx;
    beat_cnt = eff_real ? popcount(keep) : popcount({{(NUM_LANES-HALF){1'b0}}, c[HALF-1:0]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      real_q     <= 1'b1;
      comb_q     <= 2'b00;
      cfg_seen_q <= 1'b0;
    end else if (sof_beat) begin
      real_q     <= i_switch;
      comb_q     <= i_config_mode;
      cfg_seen_q <= 1'b1;
    end
  end

  // A held FIFO is kept empty by snapping its read pointer to its write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i]) begin
          rd_ptr[i] <= wr_ptr[i];
        end else begin
          if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
          if (pop_ok[i])  rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push_ok[i]) mem[i][wr_ptr[i][AW-1:0]] <= (i == 0) ? i_lf_cmp : i_hf_cmp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_data  <= '0;
      s1_keep  <= '0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= i_x0_valid;
      s1_sof   <= sof_beat;
      if (i_x0_valid) begin
        s1_data <= i_x0;
        s1_keep <= keep;
        s1_cnt  <= beat_cnt;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++)
      y_next[k*LANE_WIDTH +: LANE_WIDTH] = s1_keep[k] ? s1_data[k*LANE_WIDTH +: LANE_WIDTH] : '0;
    cnt_sum  = (s1_sof ? '0 : SW'(o_keep_cnt)) + SW'(s1_cnt);
    cnt_next = (|cnt_sum[SW-1:CNT_WIDTH]) ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_y0        <= '0;
      o_y0_valid  <= 1'b0;
      o_y0_sof    <= 1'b0;
      o_lane_keep <= '0;
      o_keep_cnt  <= '0;
      o_ovf       <= 1'b0;
      o_unf       <= 1'b0;
    end else begin
      o_y0_valid <= s1_valid;
      o_y0_sof   <= s1_valid & s1_sof;
      if (s1_valid) begin
        o_y0        <= y_next;
        o_lane_keep <= s1_keep;
        o_keep_cnt  <= cnt_next;
      end
      o_ovf <= (|ovf_evt) ? 1'b1 : (i_clr_err ? 1'b0 : o_ovf);
      o_unf <= (|unf_evt) ? 1'b1 : (i_clr_err ? 1'b0 : o_unf);
    end
  end

endmodule
